// File: rtl/puf_host_pkg.sv
// Shared types and bus bit positions for the PUF host-side sequencer.
package puf_host_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CLR,
        S_RD_ADDR,
        S_RD_CAP,
        S_RSP
    } state_e;

    localparam int CTRL_RST     = 0;
    localparam int CTRL_RST_ITF = 1;
    localparam int CTRL_LOAD    = 2;
    localparam int CTRL_READ    = 3;

    localparam int START_BIT    = 0;

endpackage

// File: rtl/puf_host_wdog.sv
// WAIT-phase timeout counter; expired flags the TIMEOUT_CYC-th enabled cycle.
module puf_host_wdog #(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Counts WAIT cycles already elapsed, so cnt == LAST marks the final permitted one.
    always_ff @(posedge clk) begin
        if (!i_rst || clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/puf_host_ctrl.sv
// Host sequencer driving the PUF interface bus: reset, load, start, wait, clear, read back.
// Optional WAIT timeout is built only when PUF_HOST_TIMEOUT_EN is defined.
module puf_host_ctrl
    import puf_host_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int N_OUT       = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_last,
    output logic             rsp_err,
    output logic [3:0]       itf_control,
    output logic [WIDTH-1:0] itf_address,
    output logic [WIDTH-1:0] itf_data_in,
    input  logic [WIDTH-1:0] itf_data_out,
    input  logic             itf_end_op
);

    localparam int               IDX_W    = $clog2(N_OUT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);
    localparam logic [WIDTH-1:0] START_M  = WIDTH'(1) << START_BIT;

    state_e           state, next;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] cfg;
    logic             err_q;
    logic             timeout_hit;
    logic             last_word;

`ifdef PUF_HOST_TIMEOUT_EN
    logic wd_expired;

    puf_host_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk     (clk),
        .i_rst   (i_rst),
        .clear   (state == S_START),
        .enable  (state == S_WAIT),
        .expired (wd_expired)
    );

    // end_op takes priority over a same-cycle expiry.
    assign timeout_hit = (state == S_WAIT) && !itf_end_op && wd_expired;
    assign rsp_err     = (state == S_RSP) && err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    assign last_word = err_q || (idx == LAST_IDX);
    assign rsp_last  = (state == S_RSP) && last_word;

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next        = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        itf_control = '0;
        itf_address = '0;
        itf_data_in = '0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) next = S_RST;
            end
            S_RST: begin
                itf_control[CTRL_RST]     = 1'b1;
                itf_control[CTRL_RST_ITF] = 1'b1;
                next = S_LOAD;
            end
            S_LOAD: begin
                itf_control[CTRL_LOAD] = 1'b1;
                itf_data_in            = cfg;
                next = S_START;
            end
            S_START: begin
                itf_control[CTRL_LOAD] = 1'b1;
                itf_data_in            = cfg | START_M;
                next = S_WAIT;
            end
            S_WAIT: begin
                if (itf_end_op)       next = S_CLR;
                else if (timeout_hit) next = S_RSP;
            end
            S_CLR: begin
                itf_control[CTRL_LOAD] = 1'b1;
                itf_data_in            = cfg;
                next = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                itf_control[CTRL_READ] = 1'b1;
                itf_address            = WIDTH'(idx);
                next = S_RD_CAP;
            end
            S_RD_CAP: begin
                next = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next = last_word ? S_IDLE : S_RD_ADDR;
            end
            default: next = S_IDLE;
        endcase
    end

    // Read data arrives the cycle after the address, so capture happens in RD_CAP.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            idx      <= '0;
            err_q    <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                S_RST: begin
                    idx   <= '0;
                    err_q <= 1'b0;
                end
                S_WAIT: begin
                    if (timeout_hit) begin
                        err_q    <= 1'b1;
                        rsp_data <= '0;
                    end
                end
                S_RD_CAP: rsp_data <= itf_data_out;
                S_RSP: begin
                    if (rsp_ready && !last_word) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && cmd_valid) cfg <= cmd_data & ~START_M;
    end

endmodule

// File: tb/tb_puf_host_ctrl.sv
// Randomized self-checking bench for puf_host_ctrl against a per-command bus/response script model.
module tb_puf_host_ctrl;

    localparam int WIDTH = 64;
    localparam int N_OUT = 2;
`ifdef PUF_HOST_TIMEOUT_EN
    localparam int TCYC = 8;
`else
    localparam int TCYC = 65535;
`endif

    logic             clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_last;
    logic             rsp_err;
    logic [3:0]       itf_control;
    logic [WIDTH-1:0] itf_address;
    logic [WIDTH-1:0] itf_data_in;
    logic [WIDTH-1:0] itf_data_out = '0;
    logic             itf_end_op = 1'b0;

    logic [63:0] mem [16];
    int checks = 0;
    int errors = 0;

    puf_host_ctrl #(.WIDTH(WIDTH), .N_OUT(N_OUT), .TIMEOUT_CYC(TCYC)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .rsp_err      (rsp_err),
        .itf_control  (itf_control),
        .itf_address  (itf_address),
        .itf_data_in  (itf_data_in),
        .itf_data_out (itf_data_out),
        .itf_end_op   (itf_end_op)
    );

    always #5 clk = ~clk;

    // Peripheral: returns mem[addr] one cycle after read, junk otherwise.
    always @(posedge clk) begin
        itf_data_out <= itf_control[3] ? mem[itf_address[3:0]] : {$urandom, $urandom};
    end

    initial begin
        #2000000;
        $display("FAIL guard: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus(input string tag, input logic [3:0] ctl, input logic [63:0] addr,
                       input logic [63:0] data);
        check({tag, "_ctl"}, 64'(itf_control), 64'(ctl));
        check({tag, "_addr"}, itf_address, addr);
        check({tag, "_din"}, itf_data_in, data);
    endtask

    task automatic rsp_phase(input logic err, input logic [63:0] data, input logic last, input int bp);
        for (int b = 0; b <= bp; b++) begin
            @(negedge clk);
            check("rsp_vld", 64'(rsp_valid), 64'h1);
            check("rsp_data", rsp_data, data);
            check("rsp_last", 64'(rsp_last), 64'(last));
            check("rsp_err", 64'(rsp_err), 64'(err));
            check("rsp_ctl", 64'(itf_control), 64'h0);
            rsp_ready  = (b == bp);
            itf_end_op = 1'($urandom);
        end
    endtask

    // One command: expected bus script derived from cfg, WAIT length and timeout rule.
    task automatic run_cmd(input logic [63:0] cfg, input int n_wait, input int bp, input int rst_at);
        logic [63:0] cfg_c;
        int          nw;
        bit          tmo;
        cfg_c = cfg & ~64'h1;
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
        tmo = (n_wait > TCYC);
        nw  = tmo ? TCYC : n_wait;

        @(negedge clk);
        check("idle_rdy", 64'(cmd_ready), 64'h1);
        cmd_valid  = 1'b1;
        cmd_data   = cfg;
        itf_end_op = 1'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = {$urandom, $urandom};
        check("busy_rdy", 64'(cmd_ready), 64'h0);
        bus("rst", 4'b0011, 64'h0, 64'h0);
        itf_end_op = 1'($urandom);
        @(negedge clk);
        bus("load", 4'b0100, 64'h0, cfg_c);
        itf_end_op = 1'($urandom);
        @(negedge clk);
        bus("start", 4'b0100, 64'h0, cfg_c | 64'h1);
        itf_end_op = 1'($urandom);

        for (int k = 0; k < nw; k++) begin
            @(negedge clk);
            bus("wait", 4'b0000, 64'h0, 64'h0);
            check("wait_vld", 64'(rsp_valid), 64'h0);
            if (k == rst_at) begin
                i_rst      = 1'b0;
                itf_end_op = 1'b0;
                @(negedge clk);
                i_rst = 1'b1;
                check("mrst_rdy", 64'(cmd_ready), 64'h1);
                check("mrst_vld", 64'(rsp_valid), 64'h0);
                bus("mrst", 4'b0000, 64'h0, 64'h0);
                return;
            end
            itf_end_op = (!tmo && k == nw - 1);
        end

        if (tmo) begin
            rsp_phase(1'b1, 64'h0, 1'b1, bp);
        end else begin
            @(negedge clk);
            itf_end_op = 1'($urandom);
            bus("clr", 4'b0100, 64'h0, cfg_c);
            for (int w = 0; w < N_OUT; w++) begin
                @(negedge clk);
                rsp_ready = 1'b0;
                bus("rdaddr", 4'b1000, 64'(w), 64'h0);
                @(negedge clk);
                bus("rdcap", 4'b0000, 64'h0, 64'h0);
                rsp_phase(1'b0, mem[w], (w == N_OUT - 1), (w == 0) ? bp : $urandom_range(0, 2));
            end
        end

        @(negedge clk);
        rsp_ready  = 1'b0;
        itf_end_op = 1'b0;
        check("done_rdy", 64'(cmd_ready), 64'h1);
        check("done_vld", 64'(rsp_valid), 64'h0);
        bus("done", 4'b0000, 64'h0, 64'h0);
    endtask

    initial begin
        i_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rdy", 64'(cmd_ready), 64'h1);
        check("reset_vld", 64'(rsp_valid), 64'h0);
        check("reset_last", 64'(rsp_last), 64'h0);
        check("reset_err", 64'(rsp_err), 64'h0);
        check("reset_data", rsp_data, 64'h0);
        bus("reset", 4'b0000, 64'h0, 64'h0);
        i_rst = 1'b1;

        run_cmd(64'h0000_0000_0003_FFFF, 20, 0, -1);
        run_cmd({$urandom, $urandom}, 5, 5, -1);
        run_cmd({$urandom, $urandom}, 1, 0, -1);
        run_cmd({$urandom, $urandom}, 10, 0, 3);
        run_cmd(64'h0000_0000_0003_FFFF, 20, 1, -1);
`ifdef PUF_HOST_TIMEOUT_EN
        run_cmd({$urandom, $urandom}, 100, 2, -1);
        run_cmd({$urandom, $urandom}, TCYC, 0, -1);
        run_cmd({$urandom, $urandom}, TCYC + 1, 0, -1);
`endif
        repeat (12) begin
            run_cmd({$urandom, $urandom}, $urandom_range(1, 12), $urandom_range(0, 3), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
